// File: rtl/bus_master_port.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_master_port : master-side transaction engine for the single-wire bus
// Revision 1.0
// ---------------------------------------------------------------------------
module bus_master_port #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int ACK_TIMEOUT   = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req,
  input  logic                     req_rd_wrt,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     done,
  output logic                     err,
  output logic                     busy,
  output logic                     bus_request,
  input  logic                     bus_grant,
  output logic                     bus_util,
  output logic                     rd_wrt,
  inout  wire                      data_bus_serial,
  inout  wire                      slave_busy
);

  localparam int HDR_W   = ADDRESS_WIDTH + 2;
  localparam int FRM_W   = DATA_WIDTH + 2;
  localparam int CNT_MAX = (HDR_W > FRM_W + 2) ? HDR_W : FRM_W + 2;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_TX_HDR, S_WAIT_ADDR_ACK, S_TX_DATA,
    S_WAIT_DATA_ACK, S_WAIT_RD, S_RX_DATA, S_DONE, S_ERROR
  } state_t;

  state_t                   state_q;
  logic                     rw_q, line_q, oe_q, sb_drv_q, prev0_q, phase_q;
  logic                     done_q, err_q, busy_q, breq_q, util_q, rdwrt_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q, rdata_q;
  logic [HDR_W-1:0]         hdr_q;
  logic [FRM_W-1:0]         frm_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     tmo_expired, fin_ok, fin_err, line_in, sb_in;

  assign data_bus_serial = oe_q ? line_q : 1'bz;
  assign slave_busy      = sb_drv_q ? 1'b1 : 1'bz;
  assign line_in         = data_bus_serial;
  assign sb_in           = slave_busy;

  assign rdata       = rdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign bus_request = breq_q;
  assign bus_util    = util_q;
  assign rd_wrt      = rdwrt_q;

  // Saturating wait counter; expiry is flagged on the edge it would reach ACK_TIMEOUT
  assign tmo_d       = (tmo_q == TMO_W'(ACK_TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);
  assign tmo_expired = (tmo_d == TMO_W'(ACK_TIMEOUT));

  always_comb begin
    fin_ok  = 1'b0;
    fin_err = 1'b0;
    case (state_q)
      S_WAIT_ADDR_ACK: fin_err = !(prev0_q && !line_in) && tmo_expired;
      S_WAIT_DATA_ACK: begin
        fin_ok  = prev0_q && line_in;
        fin_err = !fin_ok && tmo_expired;
      end
      S_WAIT_RD:       fin_err = !phase_q && !sb_in && tmo_expired;
      S_RX_DATA: begin
        fin_ok  = (cnt_q == CNT_W'(DATA_WIDTH));
        fin_err = (cnt_q == '0) && line_in && tmo_expired;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      rw_q     <= 1'b0;
      line_q   <= 1'b0;
      oe_q     <= 1'b0;
      sb_drv_q <= 1'b0;
      prev0_q  <= 1'b0;
      phase_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      breq_q   <= 1'b0;
      util_q   <= 1'b0;
      rdwrt_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      hdr_q    <= '0;
      frm_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (fin_ok || fin_err) begin
        done_q   <= fin_ok;
        err_q    <= fin_err;
        busy_q   <= 1'b0;
        breq_q   <= 1'b0;
        util_q   <= 1'b0;
        rdwrt_q  <= 1'b0;
        oe_q     <= 1'b0;
        sb_drv_q <= 1'b0;
        if (fin_ok && state_q == S_RX_DATA) rdata_q <= {frm_q[DATA_WIDTH-2:0], line_in};
        state_q  <= fin_ok ? S_DONE : S_ERROR;
      end else begin
        case (state_q)
          S_IDLE: if (req) begin
            rw_q    <= req_rd_wrt;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            busy_q  <= 1'b1;
            breq_q  <= 1'b1;
            state_q <= S_ARB;
          end
          S_ARB: if (bus_grant) begin
            util_q  <= 1'b1;
            rdwrt_q <= rw_q;
            // First start bit goes straight to the line; the rest waits in hdr_q
            hdr_q   <= {1'b0, addr_q, 1'b0};
            line_q  <= 1'b0;
            oe_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_TX_HDR;
          end
          S_TX_HDR: begin
            if (cnt_q == CNT_W'(HDR_W - 1)) begin
              oe_q    <= 1'b0;
              tmo_q   <= '0;
              prev0_q <= 1'b0;
              state_q <= S_WAIT_ADDR_ACK;
            end else begin
              line_q <= hdr_q[HDR_W-1];
              hdr_q  <= {hdr_q[HDR_W-2:0], 1'b0};
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
          S_WAIT_ADDR_ACK: begin
            prev0_q <= !line_in;
            tmo_q   <= tmo_d;
            if (prev0_q && !line_in) begin
              tmo_q   <= '0;
              cnt_q   <= '0;
              phase_q <= 1'b0;
              frm_q   <= {2'b10, wdata_q};
              state_q <= rw_q ? S_TX_DATA : S_WAIT_RD;
            end
          end
          // cnt 0..1: slave turnaround, then the 1,0,data frame from frm_q
          S_TX_DATA: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRM_W + 1)) begin
              oe_q    <= 1'b0;
              cnt_q   <= '0;
              prev0_q <= 1'b0;
              tmo_q   <= '0;
              state_q <= S_WAIT_DATA_ACK;
            end else if (cnt_q != '0) begin
              oe_q   <= 1'b1;
              line_q <= frm_q[FRM_W-1];
              frm_q  <= {frm_q[FRM_W-2:0], 1'b0};
            end
          end
          S_WAIT_DATA_ACK: begin
            prev0_q <= !line_in;
            tmo_q   <= tmo_d;
          end
          S_WAIT_RD: begin
            if (!phase_q) begin
              if (sb_in) begin
                phase_q <= 1'b1;
                tmo_q   <= '0;
              end else begin
                tmo_q <= tmo_d;
              end
            end else if (!sb_in) begin
              sb_drv_q <= 1'b1;
              cnt_q    <= '0;
              tmo_q    <= '0;
              state_q  <= S_RX_DATA;
            end
          end
          S_RX_DATA: begin
            sb_drv_q <= 1'b0;
            if (cnt_q == '0) begin
              if (!line_in) cnt_q <= CNT_W'(1);
              else          tmo_q <= tmo_d;
            end else begin
              frm_q <= {frm_q[FRM_W-2:0], line_in};
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_DONE, S_ERROR: state_q <= S_IDLE;
          default:         state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side transaction engine for the single-wire serial bus.
- Takes one parallel read/write request from a local master module and arbitrates for the bus.
- Serialises slave ID, address and write data onto data_bus_serial, then collects the slave acknowledgements or the read data.
- Returns rdata, done or err to the local side; one transaction in flight at a time.

Parameters:
- ADDRESS_WIDTH, 15, full address width; top 3 bits are the slave ID, low ADDRESS_WIDTH-3 bits are the in-slave offset.
- DATA_WIDTH, 8, data word width.
- ACK_TIMEOUT, 32, max cycles to wait for any slave response before err.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req  in  1  one-cycle request strobe; sampled only in IDLE
- req_rd_wrt  in  1  1 = write, 0 = read
- req_addr  in  ADDRESS_WIDTH  {slave_id[2:0], offset}
- req_wdata  in  DATA_WIDTH  write data
- rdata  out  DATA_WIDTH  read data, valid when done=1
- done  out  1  one-cycle success pulse
- err  out  1  one-cycle timeout pulse
- busy  out  1  high from req accept until done/err
- bus_request  out  1  request to bus arbiter
- bus_grant  in  1  grant from arbiter
- bus_util  out  1  high while this master owns the bus
- rd_wrt  out  1  registered copy of req_rd_wrt, valid while bus_util=1
- data_bus_serial  inout  1  serial line; 1'bZ when not driven, idle level high (pull-up)
- slave_busy  inout  1  wired line; driven 1 or Z only

Behaviour:
- Reset: all outputs 0, rdata 0; data_bus_serial and slave_busy released (Z); state IDLE; request registers cleared.
  - Mid-transaction reset: release lines immediately and emit no done/err.
- Bit timing: one bit per clk; driven from a register updated on posedge; MSB first for every field.
- IDLE: on req, latch the request, set busy and bus_request, go to ARB.
- ARB: wait for bus_grant.
  - Then set bus_util=1 and drive rd_wrt.
  - Go to TX_HDR with the shift register loaded as {2'b00 start, slave_id[2:0], offset}.
  - Header length is 2 + ADDRESS_WIDTH bits; it is sent contiguously.
- TX_HDR: drive one header bit per cycle; after the last bit release the line (Z), go to WAIT_ADDR_ACK.
- WAIT_ADDR_ACK:
  - Success: two consecutive 0 samples are the address ack.
  - If write, go to TX_DATA; if read, go to WAIT_RD.
  - Timeout counter runs from state entry; reaching ACK_TIMEOUT goes to ERROR.
- TX_DATA:
  - Wait 2 cycles with the line released (slave turnaround).
  - Drive 1 for one cycle, then a 0 start bit, then DATA_WIDTH data bits.
  - Release the line, go to WAIT_DATA_ACK.
- WAIT_DATA_ACK: a 0 sample followed next cycle by a 1 sample is the data ack and goes to DONE; timeout goes to ERROR.
- WAIT_RD:
  - Sequence: wait for slave_busy to be seen 1, then 0 (slave memory access finished).
  - Then drive slave_busy=1 for exactly one cycle (release request) and go to RX_DATA.
  - Timeout applies per wait phase, restarted at each phase change.
  - Timeout is suspended while slave_busy=1 (memory access may be long).
- RX_DATA:
  - Wait for a 0 start bit (ACK_TIMEOUT applies).
  - Shift in the next DATA_WIDTH bits; load rdata on the last bit; go to DONE.
- DONE: done=1 for one cycle; drop bus_util, bus_request and busy; release all lines; go to IDLE.
- ERROR: same as DONE, but pulse err instead; rdata unchanged.
- Arbitration:
  - bus_grant dropping while in ARB: stay in ARB.
  - bus_grant dropping after ARB: ignored; the transaction completes.
- req while busy: ignored, no queueing.
- done and err are never asserted together.
- Counters:
  - Timeout counter width is clog2(ACK_TIMEOUT+1); it saturates and never wraps.
  - Bit counters are clog2(ADDRESS_WIDTH+2) wide.

Test Plan:
- Write, slave model acks: req_addr=15'h2ABC, req_wdata=8'hA5, rd_wrt=1, grant after 3 cycles -> header 00,010,<offset 12'hABC> on the line; data frame 1,0,10100101; done one cycle after the 0-then-1 ack; bus_util low afterwards.
- Read: req_addr=15'h0123, slave model returns 8'h3C after a 20-cycle busy window -> master pulses slave_busy one cycle after it falls; rdata=8'h3C with done.
- No slave responds to the header -> err exactly ACK_TIMEOUT cycles after header release; no done; lines Z.
- Data ack missing after write data -> err; a subsequent write to a responsive slave completes normally.
- req asserted while busy, and bus_grant delayed 50 cycles -> the second req is ignored; the header starts on the cycle after grant.
- rstn asserted during TX_HDR bit 6 -> line Z, bus_util=0, busy=0 asynchronously; no done/err; next req works.
